// File: rtl/hero_group_ctl.sv
// N-hero lock-step movement/attack controller driven from one shared command stream.
// Optional one-deep command buffer: define HERO_GROUP_CTL_CMD_BUFFER_EN.
module hero_group_ctl #(
   parameter int                           N_HEROES    = 2,
   parameter int                           COORD_W     = 12,
   parameter int                           SQUARE      = 60,
   parameter int                           MOVE_TIME   = 60,
   parameter int                           ATTACK_TIME = 60,
   parameter int                           ATK_W       = 20,
   parameter int                           ATK_H       = 40,
   parameter int                           X_MIN       = 62,
   parameter int                           X_MAX       = 962,
   parameter int                           Y_MIN       = 108,
   parameter int                           Y_MAX       = 708,
   parameter logic [N_HEROES-1:0]          MIRROR_MASK = 2'b10,
   parameter logic [N_HEROES*COORD_W-1:0]  X_INIT      = {12'd422, 12'd542},
   parameter logic [N_HEROES*COORD_W-1:0]  Y_INIT      = {12'd648, 12'd648},
   parameter int                           PARK_X      = 1025,
   parameter int                           PARK_Y      = 0
) (
   input  logic                           clk_div,
   input  logic                           rst,
   input  logic                           up,
   input  logic                           left,
   input  logic                           right,
   input  logic                           down,
   input  logic                           center,
   input  logic [4*N_HEROES-1:0]          collision,
   output logic [N_HEROES*COORD_W-1:0]    x_pos,
   output logic [N_HEROES*COORD_W-1:0]    y_pos,
   output logic [N_HEROES*COORD_W-1:0]    x_atk,
   output logic [N_HEROES*COORD_W-1:0]    y_atk,
   output logic                           atk_dir,
   output logic [1:0]                     facing,
   output logic                           busy,
   output logic                           step_done
);

   localparam int CW    = COORD_W;
   localparam int CW1   = COORD_W + 1;
   localparam int T_MAX = (MOVE_TIME > ATTACK_TIME) ? MOVE_TIME : ATTACK_TIME;
   localparam int CNT_W = $clog2(T_MAX + 1);

   localparam logic [CNT_W-1:0] MOVE_END  = CNT_W'(MOVE_TIME);
   localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIME - 1);
   localparam logic [CNT_W-1:0] ATK_END   = CNT_W'(ATTACK_TIME);

   // x-1 >= X_MIN rewritten as x >= X_MIN+1 so it cannot wrap below zero
   localparam logic [CW1-1:0] X_LO   = CW1'(X_MIN + 1);
   localparam logic [CW1-1:0] Y_LO   = CW1'(Y_MIN + 1);
   localparam logic [CW1-1:0] X_HI   = CW1'(X_MAX);
   localparam logic [CW1-1:0] Y_HI   = CW1'(Y_MAX);
   localparam logic [CW1-1:0] SQ_P1  = CW1'(SQUARE + 1);

   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW-1:0] SQ    = CW'(SQUARE);
   localparam logic [CW-1:0] AW    = CW'(ATK_W);
   localparam logic [CW-1:0] AH    = CW'(ATK_H);
   localparam logic [CW-1:0] PX    = CW'(PARK_X);
   localparam logic [CW-1:0] PY    = CW'(PARK_Y);

   localparam logic [1:0] D_UP    = 2'd0;
   localparam logic [1:0] D_LEFT  = 2'd1;
   localparam logic [1:0] D_RIGHT = 2'd2;
   localparam logic [1:0] D_DOWN  = 2'd3;

   typedef enum logic [1:0] {IDLE, MOVE, ATTACK} state_t;

   state_t                      state;
   logic [CNT_W-1:0]            cnt;
   logic                        cmd_valid;
   logic                        cmd_atk;
   logic [1:0]                  cmd_dir;
   logic                        terminal;
   logic [N_HEROES*CW-1:0]      mv_x;
   logic [N_HEROES*CW-1:0]      mv_y;
   logic [N_HEROES*CW-1:0]      ax;
   logic [N_HEROES*CW-1:0]      ay;

`ifdef HERO_GROUP_CTL_CMD_BUFFER_EN
   logic                        pend_valid;
   logic                        pend_atk;
   logic [1:0]                  pend_dir;
`endif

   always_comb begin
      cmd_valid = 1'b1;
      cmd_atk   = 1'b0;
      cmd_dir   = D_UP;
      if (up)          cmd_dir = D_UP;
      else if (left)   cmd_dir = D_LEFT;
      else if (right)  cmd_dir = D_RIGHT;
      else if (down)   cmd_dir = D_DOWN;
      else if (center) cmd_atk = 1'b1;
      else             cmd_valid = 1'b0;
   end

   assign terminal = ((state == MOVE) && (cnt == MOVE_END)) ||
                     ((state == ATTACK) && (cnt == ATK_END));

   // Per-hero next position and attack box, from facing mapped to screen direction
   always_comb begin
      logic [1:0]    sd;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      mv_x = x_pos;
      mv_y = y_pos;
      ax   = x_atk;
      ay   = y_atk;
      for (int unsigned i = 0; i < N_HEROES; i++) begin
         x  = x_pos[i*CW +: CW];
         y  = y_pos[i*CW +: CW];
         sd = facing;
         if (MIRROR_MASK[i] && (facing == D_LEFT || facing == D_RIGHT))
            sd = ~facing;
         case (sd)
            D_UP: begin
               if (({1'b0, y} >= Y_LO) && !collision[4*i+3]) mv_y[i*CW +: CW] = y - ONE;
               ax[i*CW +: CW] = x + AW;
               ay[i*CW +: CW] = y - AH;
            end
            D_LEFT: begin
               if (({1'b0, x} >= X_LO) && !collision[4*i]) mv_x[i*CW +: CW] = x - ONE;
               ax[i*CW +: CW] = x - AH;
               ay[i*CW +: CW] = y + AW;
            end
            D_RIGHT: begin
               if (({1'b0, x} + SQ_P1 <= X_HI) && !collision[4*i+1]) mv_x[i*CW +: CW] = x + ONE;
               ax[i*CW +: CW] = x + SQ;
               ay[i*CW +: CW] = y + AW;
            end
            default: begin
               if (({1'b0, y} + SQ_P1 <= Y_HI) && !collision[4*i+2]) mv_y[i*CW +: CW] = y + ONE;
               ax[i*CW +: CW] = x + AW;
               ay[i*CW +: CW] = y + SQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         x_pos     <= X_INIT;
         y_pos     <= Y_INIT;
         x_atk     <= {N_HEROES{PX}};
         y_atk     <= {N_HEROES{PY}};
         atk_dir   <= 1'b0;
         facing    <= D_UP;
         busy      <= 1'b0;
         step_done <= 1'b0;
`ifdef HERO_GROUP_CTL_CMD_BUFFER_EN
         pend_valid <= 1'b0;
         pend_atk   <= 1'b0;
         pend_dir   <= D_UP;
`endif
      end else begin
         step_done <= 1'b0;
`ifdef HERO_GROUP_CTL_CMD_BUFFER_EN
         // Terminal tick never captures: a pending command is consumed there, or the FSM drops to IDLE
         if ((state != IDLE) && !terminal && !pend_valid && cmd_valid) begin
            pend_valid <= 1'b1;
            pend_atk   <= cmd_atk;
            pend_dir   <= cmd_dir;
         end
`endif
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  state <= cmd_atk ? ATTACK : MOVE;
                  if (!cmd_atk) facing <= cmd_dir;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            MOVE: begin
               if (!terminal) begin
                  x_pos     <= mv_x;
                  y_pos     <= mv_y;
                  cnt       <= cnt + 1'b1;
                  step_done <= (cnt == MOVE_LAST);
               end else begin
                  cnt <= '0;
               end
            end
            ATTACK: begin
               if (!terminal) begin
                  x_atk   <= ax;
                  y_atk   <= ay;
                  atk_dir <= facing[0] ^ facing[1];
                  cnt     <= cnt + 1'b1;
               end else begin
                  x_atk   <= {N_HEROES{PX}};
                  y_atk   <= {N_HEROES{PY}};
                  atk_dir <= 1'b0;
                  cnt     <= '0;
               end
            end
            default: state <= IDLE;
         endcase
         if (terminal) begin
`ifdef HERO_GROUP_CTL_CMD_BUFFER_EN
            if (pend_valid) begin
               state      <= pend_atk ? ATTACK : MOVE;
               if (!pend_atk) facing <= pend_dir;
               pend_valid <= 1'b0;
            end else
`endif
            begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hero_group_ctl.sv
// Directed bench for hero_group_ctl with hand-computed expected values.
module tb_hero_group_ctl;

   logic        clk_div = 1'b0;
   logic        rst = 1'b1;
   logic        up = 1'b0;
   logic        left = 1'b0;
   logic        right = 1'b0;
   logic        down = 1'b0;
   logic        center = 1'b0;
   logic [7:0]  collision = '0;
   logic [23:0] x_pos;
   logic [23:0] y_pos;
   logic [23:0] x_atk;
   logic [23:0] y_atk;
   logic        atk_dir;
   logic [1:0]  facing;
   logic        busy;
   logic        step_done;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [4:0] C_UP     = 5'b10000;
   localparam logic [4:0] C_LEFT   = 5'b01000;
   localparam logic [4:0] C_RIGHT  = 5'b00100;
   localparam logic [4:0] C_DOWN   = 5'b00010;
   localparam logic [4:0] C_CENTER = 5'b00001;

   always #5 clk_div = ~clk_div;

   hero_group_ctl dut (
      .clk_div   (clk_div),
      .rst       (rst),
      .up        (up),
      .left      (left),
      .right     (right),
      .down      (down),
      .center    (center),
      .collision (collision),
      .x_pos     (x_pos),
      .y_pos     (y_pos),
      .x_atk     (x_atk),
      .y_atk     (y_atk),
      .atk_dir   (atk_dir),
      .facing    (facing),
      .busy      (busy),
      .step_done (step_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge clk_div);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
   endtask

   task automatic pulse(input logic [4:0] cmd);
      {up, left, right, down, center} = cmd;
      ticks(1);
      {up, left, right, down, center} = '0;
   endtask

   initial begin
      #12;
      check("rst_x_pos", x_pos, {12'd422, 12'd542});
      check("rst_y_pos", y_pos, {12'd648, 12'd648});
      check("rst_x_atk", x_atk, {12'd1025, 12'd1025});
      check("rst_y_atk", y_atk, 24'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_facing", facing, 2'd0);
      check("rst_step_done", step_done, 1'b0);
      check("rst_atk_dir", atk_dir, 1'b0);
      rst = 1'b0;
      ticks(1);

      // up move: 60 pixels, step_done on the 61st tick
      pulse(C_UP);
      check("up_busy", busy, 1'b1);
      check("up_y_start", y_pos, {12'd648, 12'd648});
      ticks(59);
      check("up_y_59", y_pos, {12'd589, 12'd589});
      check("up_step_early", step_done, 1'b0);
      ticks(1);
      check("up_y_60", y_pos, {12'd588, 12'd588});
      check("up_step_done", step_done, 1'b1);
      check("up_busy_term", busy, 1'b1);
      ticks(1);
      check("up_idle_busy", busy, 1'b0);
      check("up_idle_step", step_done, 1'b0);

      // left move with hero1 mirrored
      do_reset();
      pulse(C_LEFT);
      ticks(60);
      check("left_x", x_pos, {12'd482, 12'd482});
      check("left_facing", facing, 2'd1);
      check("left_step", step_done, 1'b1);
      ticks(1);
      check("left_idle", busy, 1'b0);

      // hero0 left blocked by collision
      do_reset();
      collision = 8'h01;
      pulse(C_LEFT);
      ticks(60);
      check("coll_x", x_pos, {12'd482, 12'd542});
      check("coll_step", step_done, 1'b1);
      collision = '0;
      ticks(1);

      // down blocked by bottom bound
      do_reset();
      pulse(C_DOWN);
      ticks(60);
      check("down_y", y_pos, {12'd648, 12'd648});
      check("down_step", step_done, 1'b1);
      ticks(1);
      check("down_idle", busy, 1'b0);
      check("down_facing", facing, 2'd3);

      // attack facing up
      do_reset();
      pulse(C_CENTER);
      check("atk_busy", busy, 1'b1);
      check("atk_x_entry", x_atk, {12'd1025, 12'd1025});
      ticks(1);
      check("atk_x", x_atk, {12'd442, 12'd562});
      check("atk_y", y_atk, {12'd608, 12'd608});
      check("atk_dir_up", atk_dir, 1'b0);
      check("atk_pos_frozen", x_pos, {12'd422, 12'd542});
      ticks(59);
      check("atk_x_last", x_atk, {12'd442, 12'd562});
      check("atk_busy_last", busy, 1'b1);
      ticks(1);
      check("atk_park_x", x_atk, {12'd1025, 12'd1025});
      check("atk_park_y", y_atk, 24'd0);
      check("atk_idle", busy, 1'b0);

      // attack facing left after a left move (hero1 box on the right side)
      do_reset();
      pulse(C_LEFT);
      ticks(61);
      pulse(C_CENTER);
      ticks(1);
      check("atkl_x", x_atk, {12'd542, 12'd442});
      check("atkl_y", y_atk, {12'd668, 12'd668});
      check("atkl_dir", atk_dir, 1'b1);
      ticks(60);
      check("atkl_idle", busy, 1'b0);

      // reset mid-move aborts
      pulse(C_UP);
      ticks(10);
      do_reset();
      check("abort_y", y_pos, {12'd648, 12'd648});
      check("abort_busy", busy, 1'b0);
      check("abort_facing", facing, 2'd0);

      // right pulsed mid-up-move
      ticks(1);
      pulse(C_UP);
      ticks(10);
      pulse(C_RIGHT);
      ticks(49);
      check("buf_up_done", y_pos, {12'd588, 12'd588});
      check("buf_up_step", step_done, 1'b1);
      ticks(1);
`ifdef HERO_GROUP_CTL_CMD_BUFFER_EN
      check("buf_busy_kept", busy, 1'b1);
      check("buf_facing", facing, 2'd2);
      ticks(60);
      check("buf_right_x", x_pos, {12'd362, 12'd602});
      check("buf_right_step", step_done, 1'b1);
      ticks(1);
      check("buf_idle", busy, 1'b0);
`else
      check("nobuf_idle", busy, 1'b0);
      check("nobuf_facing", facing, 2'd0);
      ticks(1);
      check("nobuf_still_idle", busy, 1'b0);
      check("nobuf_x", x_pos, {12'd422, 12'd542});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
